pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a datapath bundle, control bundle and destination-register field across one stage boundary.
- Adds valid/ready handshake, 2-entry skid buffer, synchronous flush, bubble control-kill and link-register override.
- in_ready is registered, so no combinational ready path crosses the stage; breaks long stall chains between pipeline stages.

Parameters:
- DATA_W, 64: width of concatenated datapath payload, e.g. ALU result plus store data.
- CTRL_W, 12: width of control bundle (branch, mem, regwrite, jump, trunk mode...).
- REG_ADDR_W, 5: destination register field width.
- LINK_REG, 31: register index forced when in_link is set.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  datapath payload.
- in_ctrl  in  CTRL_W  control payload.
- in_wreg  in  REG_ADDR_W  destination register.
- in_link  in  1  instruction saves PC; forces destination to LINK_REG.
- flush  in  1  discard all held and incoming entries.
- out_valid  out  1  downstream bundle valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload.
- out_ctrl  out  CTRL_W  control; all-zero whenever out_valid=0.
- out_wreg  out  REG_ADDR_W  destination register.
- out_link  out  1  link flag.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main entry (drives outputs) and skid entry. State EMPTY / ONE / FULL; occupancy encodes state as 0/1/2.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. in_ready = (state != FULL), taken from the state register. out_valid = (state != EMPTY).
- On capture, the stored wreg is LINK_REG if in_link=1, else in_wreg. in_link is stored alongside.
- EMPTY:
  - in_fire -> ONE, main <= input.
  - Otherwise stay.
- ONE:
  - in_fire & out_fire -> ONE, main <= input.
  - out_fire only -> EMPTY.
  - in_fire only -> FULL, skid <= input.
  - Neither -> hold.
- FULL:
  - out_fire -> ONE, main <= skid.
  - Otherwise hold. No input accepted.
- Ordering: strict FIFO. No entry is duplicated or dropped except by flush.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Full throughput of 1/cycle when out_ready is held high.
- flush=1 at an edge: next state EMPTY and occupancy 0. Any same-cycle in_fire is discarded. Flush has priority over all transitions. Stored data contents are don't-care after flush.
- Bubble kill: out_ctrl = stored ctrl & {CTRL_W{out_valid}}, so an invalid stage never asserts RegWrite or MemWrite downstream. out_data, out_wreg and out_link hold their last value while invalid.
- Reset, asserted asynchronously: state EMPTY, so out_valid=0, in_ready=1, occupancy=0. out_ctrl=0, out_data=0, out_wreg=0, out_link=0, skid contents=0. No transfer occurs while reset is high.
- Reset mid-operation: all held entries are lost. First capture is possible on the first rising edge after deassertion.
- Unchanging held data: while out_valid=1 & out_ready=0, all out_* are stable.

Decomposition:
- Shared pipeline package: state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and default LINK_REG constant 5'd31.
- One sub-module, pipe_entry_reg: a single DATA_W+CTRL_W+REG_ADDR_W+1 register with load enable and async reset. Instantiated twice, for main and skid.
- Top level holds the FSM, link-override mux and ctrl-kill gating.

Test Plan:
- Reset then single transfer: in_valid=1, in_data=0x1234_5678, in_wreg=7, in_link=0, out_ready=1 -> next cycle out_valid=1, out_data=0x1234_5678, out_wreg=7, occupancy=1.
- Link override: in_link=1, in_wreg=4 -> out_wreg=31, out_link=1.
- Backpressure/skid: out_ready=0; send A then B -> occupancy 1 then 2, in_ready=0 after B. Raise out_ready -> A then B emerge on consecutive cycles, in_ready=1 after A leaves.
- Streaming: out_ready=1; send 100 back-to-back incrementing words -> out sequence identical, one word per cycle, latency 1, occupancy never 2.
- Flush while FULL, with a simultaneous in_valid=1 -> next cycle out_valid=0, occupancy=0, out_ctrl=0, and the flushed input never appears.
- Async reset mid-stream, pulsed between edges -> out_valid=0 and out_ctrl=0 immediately. The next input after deassertion emerges with latency 1.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: state encoding
// (which doubles as the occupancy count) and the default link register.
package pipe_stage_skid_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [4:0] LINK_REG_DFLT = 5'd31;

endpackage

// File: rtl/pipe_entry_reg.sv
// One stored pipeline entry: a load-enabled register that clears on reset.
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Capture the entry when loaded, otherwise hold it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a two-entry
// skid buffer. in_ready comes straight from the state register, so no
// combinational ready path crosses the stage boundary.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int          DATA_W     = 64,
    parameter int          CTRL_W     = 12,
    parameter int          REG_ADDR_W = 5,
    parameter int unsigned LINK_REG   = int'(LINK_REG_DFLT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [REG_ADDR_W-1:0] in_wreg,
    input  logic                  in_link,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [REG_ADDR_W-1:0] out_wreg,
    output logic                  out_link,
    output logic [1:0]            occupancy
);

    localparam int EW = DATA_W + CTRL_W + REG_ADDR_W + 1;

    logic [1:0]            state_q, state_d;
    logic                  in_fire, out_fire;
    logic [REG_ADDR_W-1:0] wreg_sel;
    logic [EW-1:0]         cap_d;
    logic [EW-1:0]         main_d, main_q, skid_q;
    logic                  main_ld, skid_ld;
    logic [CTRL_W-1:0]     main_ctrl;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Linking instructions always write the link register.
    assign wreg_sel = in_link ? REG_ADDR_W'(LINK_REG) : in_wreg;
    assign cap_d    = {in_data, in_ctrl, wreg_sel, in_link};

    // Next-state and entry-load decode; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = cap_d;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_ld = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State register; reset empties the stage immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_entry_reg #(.W(EW)) u_main (
        .clk    (clk),
        .reset  (reset),
        .load_i (main_ld),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_entry_reg #(.W(EW)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load_i (skid_ld),
        .d_i    (cap_d),
        .q_o    (skid_q)
    );

    assign {out_data, main_ctrl, out_wreg, out_link} = main_q;

    // Bubbles must never carry live control (RegWrite, MemWrite) downstream.
    assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};

endmodule
